anita3_phi_coincidence_trigger: RTL and testbench
=================================================

// Module: anita3_phi_coincidence_trigger
// PURPOSE
//  Downstream of the phi-sector trigger map. Consumes the masked 16-sector V/H L1 phi patterns,
//  stretches each hit, forms a neighbouring-sector coincidence per polarisation (with wrap-around),
//  and issues one global trigger record (latched V/H phi patterns) over a valid/ready handshake,
//  followed by a programmable holdoff. Triggers arriving while busy are dropped and counted.
// PARAMETERS
//  NUM_PHI      16   phi sectors per polarisation (must be >=3)
//  STRETCH_LEN  4    cycles each L1 rising edge is stretched (1..255; 1 = single-cycle pulse)
//  HOLDOFF_LEN  32   cycles of holdoff after a record is accepted (0..65535; 0 = none)
// PORTS
//  clk250_i      in   1        250 MHz trigger clock
//  rst_n_i       in   1        reset, asynchronous, active-low
//  enable_i      in   1        1 = new triggers may be issued
//  pol_en_i      in   2        [0] V coincidence enable, [1] H coincidence enable
//  V_pol_phi_i   in   NUM_PHI  masked V-pol phi L1 bits from the trigger map
//  H_pol_phi_i   in   NUM_PHI  masked H-pol phi L1 bits from the trigger map
//  trig_valid_o  out  1        trigger record valid
//  trig_ready_i  in   1        consumer accepts record when valid&ready
//  trig_V_phi_o  out  NUM_PHI  V sectors in coincidence at trigger time
//  trig_H_phi_o  out  NUM_PHI  H sectors in coincidence at trigger time
//  busy_o        out  1        1 in WAIT or HOLDOFF
//  dropped_o     out  16       saturating count of candidates lost while busy or disabled
// BEHAVIOUR
//  - Reset: all outputs, counters, stretch counters and input registers 0; state IDLE.
//  - Stage 1: V/H inputs registered; rising edge = cur & ~prev (prev also registered).
//  - Stage 2 (stretch): rising edge loads counter with STRETCH_LEN; s[j] = (cnt!=0); counter
//    decrements when nonzero. A new rising edge while stretched reloads to STRETCH_LEN.
//  - Stage 3 (coincidence, registered): c[j] = s[j] & (s[(j-1) mod NUM_PHI] | s[(j+1) mod NUM_PHI]);
//    sector 0 neighbours NUM_PHI-1 and 1. cV gated by pol_en_i[0], cH by pol_en_i[1].
//    candidate = |cV | |cH.
//  - Latency: input edge at clock k -> trig_valid_o high after clock k+3 (FSM registered).
//  - FSM IDLE: candidate & enable_i -> latch cV/cH into trig_*_phi_o, valid=1, go WAIT.
//    candidate & ~enable_i -> dropped_o++ , stay IDLE.
//  - WAIT: valid held, record stable. valid&ready -> valid=0, patterns cleared; go HOLDOFF with
//    counter=HOLDOFF_LEN, or IDLE directly if HOLDOFF_LEN==0. enable_i falling never retracts valid.
//  - HOLDOFF: counter decrements; at 1 -> IDLE next cycle (exactly HOLDOFF_LEN busy cycles).
//  - Any candidate cycle in WAIT or HOLDOFF increments dropped_o (one per cycle, not per edge).
//  - dropped_o saturates at 16'hFFFF; never wraps.
//  - Candidate on the same cycle HOLDOFF->IDLE transitions: counted as dropped (FSM still busy).
//  - Async reset mid-WAIT: valid drops immediately; record lost, not counted.
// CONFIGURATION
//  DEADTIME_COUNT_EN defined: adds output deadtime_o [31:0], counting clk250_i cycles with
//  busy_o=1; saturates at 32'hFFFFFFFF; reset to 0. Undefined: port and counter absent; all
//  other behaviour identical.
// STRUCTURE
//  - Shared package anita3_trig_pkg: NUM_PHI default, trig_state_t {IDLE, WAIT, HOLDOFF},
//    STRETCH/HOLDOFF width constants.
//  - Sub-module anita3_phi_stretch: one per bit (2*NUM_PHI instances): edge detect + reload
//    counter, ports clk250_i, rst_n_i, hit_i, stretched_o.
//  - Top holds coincidence logic, FSM, dropped/deadtime counters.
// TESTING
//  - V_pol_phi_i[5] and [6] high 1 cycle together, enable=1, pol_en=2'b01 -> valid 3 cycles
//    later, trig_V_phi_o=16'h0060, trig_H_phi_o=0.
//  - Wrap: H bits 15 then 0 two cycles apart, STRETCH_LEN=4, pol_en=2'b10 -> trig_H_phi_o=16'h8001;
//    same with 6-cycle gap -> no trigger.
//  - Isolated hit on V[3] alone -> no valid; dropped_o unchanged.
//  - Hold ready=0 20 cycles while coincidences continue every cycle -> record stable, dropped_o
//    counts each candidate cycle; ready=1 -> busy_o for exactly HOLDOFF_LEN=32 cycles afterward.
//  - enable_i=0 with coincidence -> no valid, dropped_o+1; force dropped to 16'hFFFF -> stays.
//  - rst_n_i low mid-WAIT -> valid 0 asynchronously; DEADTIME_COUNT_EN build: deadtime_o equals
//    busy cycle count (e.g. 1 WAIT + 32 HOLDOFF = 33).

Source files
------------

// File: rtl/anita3_trig_pkg.sv
// Shared types and constants for the ANITA-3 phi-sector coincidence trigger.
package anita3_trig_pkg;

  localparam int NUM_PHI_DEF = 16;
  localparam int STRETCH_W   = 8;   // holds STRETCH_LEN up to 255
  localparam int HOLDOFF_W   = 16;  // holds HOLDOFF_LEN up to 65535
  localparam int DROP_W      = 16;
  localparam int DEAD_W      = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

endpackage

// File: rtl/anita3_phi_stretch.sv
// Per-sector hit conditioning: registers the L1 bit, detects its rising edge and
// stretches it to STRETCH_LEN cycles. A fresh edge while stretched restarts the window.
module anita3_phi_stretch
  import anita3_trig_pkg::*;
#(
  parameter int STRETCH_LEN = 4
) (
  input  logic clk250_i,
  input  logic rst_n_i,
  input  logic hit_i,
  output logic stretched_o
);

  logic                 r_cur;
  logic                 r_prev;
  logic [STRETCH_W-1:0] r_cnt;
  logic                 w_rise;

  assign w_rise = r_cur & ~r_prev;

  // Input register, edge history and reload-style stretch down-counter.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cur  <= hit_i;
      r_prev <= r_cur;
      if (w_rise)
        r_cnt <= STRETCH_W'(STRETCH_LEN);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign stretched_o = (r_cnt != '0);

endmodule

// File: rtl/anita3_phi_coincidence_trigger.sv
// Neighbouring-sector phi coincidence per polarisation, one trigger record per
// valid/ready handshake, then a programmable holdoff. Candidates lost while busy or
// disabled are counted in a saturating counter.
// Optional build macro DEADTIME_COUNT_EN adds deadtime_o (busy-cycle counter).
//
// state   | meaning
// IDLE    | armed, waiting for a coincidence candidate
// WAIT    | record presented, waiting for trig_ready_i
// HOLDOFF | record consumed, counting down HOLDOFF_LEN cycles
module anita3_phi_coincidence_trigger
  import anita3_trig_pkg::*;
#(
  parameter int NUM_PHI     = NUM_PHI_DEF,
  parameter int STRETCH_LEN = 4,
  parameter int HOLDOFF_LEN = 32
) (
  input  logic               clk250_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  input  logic [1:0]         pol_en_i,
  input  logic [NUM_PHI-1:0] V_pol_phi_i,
  input  logic [NUM_PHI-1:0] H_pol_phi_i,
  output logic               trig_valid_o,
  input  logic               trig_ready_i,
  output logic [NUM_PHI-1:0] trig_V_phi_o,
  output logic [NUM_PHI-1:0] trig_H_phi_o,
  output logic               busy_o,
  output logic [DROP_W-1:0]  dropped_o
`ifdef DEADTIME_COUNT_EN
  ,
  output logic [DEAD_W-1:0]  deadtime_o
`endif
);

  logic [NUM_PHI-1:0] w_sv, w_sh;
  logic [NUM_PHI-1:0] w_cv, w_ch;
  logic [NUM_PHI-1:0] r_cv, r_ch;
  logic               w_cand;

  trig_state_t          r_state, w_state_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [NUM_PHI-1:0]   r_vphi, w_vphi_nxt;
  logic [NUM_PHI-1:0]   r_hphi, w_hphi_nxt;
  logic [HOLDOFF_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [DROP_W-1:0]    r_dropped;
  logic                 w_busy;
  logic                 w_drop_inc;

  for (genvar g = 0; g < NUM_PHI; g++) begin : g_stretch
    anita3_phi_stretch #(.STRETCH_LEN(STRETCH_LEN)) u_str_v (
      .clk250_i    (clk250_i),
      .rst_n_i     (rst_n_i),
      .hit_i       (V_pol_phi_i[g]),
      .stretched_o (w_sv[g])
    );
    anita3_phi_stretch #(.STRETCH_LEN(STRETCH_LEN)) u_str_h (
      .clk250_i    (clk250_i),
      .rst_n_i     (rst_n_i),
      .hit_i       (H_pol_phi_i[g]),
      .stretched_o (w_sh[g])
    );
  end

  // Sector coincides when it and at least one ring neighbour are stretched.
  always_comb begin
    w_cv = '0;
    w_ch = '0;
    for (int j = 0; j < NUM_PHI; j++) begin
      w_cv[j] = w_sv[j] & (w_sv[(j + NUM_PHI - 1) % NUM_PHI] | w_sv[(j + 1) % NUM_PHI]);
      w_ch[j] = w_sh[j] & (w_sh[(j + NUM_PHI - 1) % NUM_PHI] | w_sh[(j + 1) % NUM_PHI]);
    end
    if (!pol_en_i[0]) w_cv = '0;
    if (!pol_en_i[1]) w_ch = '0;
  end

  // Coincidence register stage.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cv <= '0;
      r_ch <= '0;
    end else begin
      r_cv <= w_cv;
      r_ch <= w_ch;
    end
  end

  assign w_cand     = (|r_cv) | (|r_ch);
  assign w_busy     = (r_state != IDLE);
  assign w_drop_inc = w_cand & (w_busy | ~enable_i);

  // Next-state and record logic.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_vphi_nxt  = r_vphi;
    w_hphi_nxt  = r_hphi;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_cand && enable_i) begin
          w_state_nxt = WAIT;
          w_valid_nxt = 1'b1;
          w_vphi_nxt  = r_cv;
          w_hphi_nxt  = r_ch;
        end
      end
      WAIT: begin
        if (trig_ready_i) begin
          w_valid_nxt = 1'b0;
          w_vphi_nxt  = '0;
          w_hphi_nxt  = '0;
          if (HOLDOFF_LEN == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLDOFF;
            w_hold_nxt  = HOLDOFF_W'(HOLDOFF_LEN);
          end
        end
      end
      HOLDOFF: begin
        if (r_hold_cnt <= HOLDOFF_W'(1)) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt  = r_hold_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_vphi_nxt  = '0;
        w_hphi_nxt  = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // State, record and saturating drop counter registers.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_vphi     <= '0;
      r_hphi     <= '0;
      r_hold_cnt <= '0;
      r_dropped  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_vphi     <= w_vphi_nxt;
      r_hphi     <= w_hphi_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_drop_inc && (r_dropped != {DROP_W{1'b1}}))
        r_dropped <= r_dropped + 1'b1;
    end
  end

`ifdef DEADTIME_COUNT_EN
  logic [DEAD_W-1:0] r_dead;

  // Saturating count of busy cycles.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_dead <= '0;
    else if (w_busy && (r_dead != {DEAD_W{1'b1}}))
      r_dead <= r_dead + 1'b1;
  end

  assign deadtime_o = r_dead;
`endif

  assign trig_valid_o = r_valid;
  assign trig_V_phi_o = r_vphi;
  assign trig_H_phi_o = r_hphi;
  assign busy_o       = w_busy;
  assign dropped_o    = r_dropped;

endmodule

// File: tb/tb_anita3_phi_coincidence_trigger.sv
// Directed self-checking bench for anita3_phi_coincidence_trigger (defaults 16/4/32).
module tb_anita3_phi_coincidence_trigger;

  logic        clk250_i;
  logic        rst_n_i;
  logic        enable_i;
  logic [1:0]  pol_en_i;
  logic [15:0] V_pol_phi_i;
  logic [15:0] H_pol_phi_i;
  logic        trig_valid_o;
  logic        trig_ready_i;
  logic [15:0] trig_V_phi_o;
  logic [15:0] trig_H_phi_o;
  logic        busy_o;
  logic [15:0] dropped_o;
`ifdef DEADTIME_COUNT_EN
  logic [31:0] deadtime_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_drop;

  anita3_phi_coincidence_trigger dut (
    .clk250_i     (clk250_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .pol_en_i     (pol_en_i),
    .V_pol_phi_i  (V_pol_phi_i),
    .H_pol_phi_i  (H_pol_phi_i),
    .trig_valid_o (trig_valid_o),
    .trig_ready_i (trig_ready_i),
    .trig_V_phi_o (trig_V_phi_o),
    .trig_H_phi_o (trig_H_phi_o),
    .busy_o       (busy_o),
    .dropped_o    (dropped_o)
`ifdef DEADTIME_COUNT_EN
    ,
    .deadtime_o   (deadtime_o)
`endif
  );

  initial clk250_i = 1'b0;
  always #5 clk250_i = ~clk250_i;

  task automatic tick();
    @(posedge clk250_i);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout: busy=%b want 0", tag, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; enable_i = 1'b1; pol_en_i = 2'b00; trig_ready_i = 1'b1;
    V_pol_phi_i = '0; H_pol_phi_i = '0;
    repeat (3) tick();
    rst_n_i = 1'b1;
    tick();
    total++; if (trig_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", trig_valid_o); end
    total++; if (trig_V_phi_o !== 16'h0 || trig_H_phi_o !== 16'h0) begin bad++; $display("FAIL reset_phi: got %h/%h want 0/0", trig_V_phi_o, trig_H_phi_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (dropped_o !== 16'h0) begin bad++; $display("FAIL reset_dropped: got %h want 0", dropped_o); end
    exp_drop = 16'h0;
  endtask

  // V5+V6 one cycle; H carries the same pattern but H is not enabled.
  task automatic test_basic_v();
    enable_i = 1'b1; pol_en_i = 2'b01; trig_ready_i = 1'b1;
    V_pol_phi_i = 16'h0060; H_pol_phi_i = 16'h0060;
    tick();                                  // edge k
    V_pol_phi_i = '0; H_pol_phi_i = '0;
    tick(); tick();                          // k+1, k+2
    total++; if (trig_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early: valid=%b want 0 at k+2", trig_valid_o); end
    tick();                                  // k+3
    total++; if (trig_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid: valid=%b want 1 at k+3", trig_valid_o); end
    total++; if (trig_V_phi_o !== 16'h0060) begin bad++; $display("FAIL basic_vphi: got %h want 0060", trig_V_phi_o); end
    total++; if (trig_H_phi_o !== 16'h0000) begin bad++; $display("FAIL basic_hphi: got %h want 0000", trig_H_phi_o); end
    tick();                                  // k+4: accepted
    total++; if (trig_valid_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("FAIL basic_accept: valid=%b busy=%b want 0/1", trig_valid_o, busy_o); end
    total++; if (trig_V_phi_o !== 16'h0) begin bad++; $display("FAIL basic_clear: got %h want 0000", trig_V_phi_o); end
    repeat (31) tick();                      // k+35: last holdoff cycle
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_holdoff_end: busy=%b want 1 at k+35", busy_o); end
    tick();                                  // k+36
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_idle: busy=%b want 0 at k+36", busy_o); end
    exp_drop = 16'd3;
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL basic_dropped: got %0d want %0d", dropped_o, exp_drop); end
`ifdef DEADTIME_COUNT_EN
    total++; if (deadtime_o !== 32'd33) begin bad++; $display("FAIL basic_deadtime: got %0d want 33", deadtime_o); end
`endif
  endtask

  task automatic test_wrap();
    int lat;
    logic [15:0] got_h, got_v;
    enable_i = 1'b1; pol_en_i = 2'b10; trig_ready_i = 1'b1;
    H_pol_phi_i = 16'h8000; tick();          // k
    H_pol_phi_i = '0;       tick();          // k+1
    H_pol_phi_i = 16'h0001; tick();          // k+2
    H_pol_phi_i = '0;
    lat = -1; got_h = '0; got_v = '0;
    for (int n = 3; n <= 12; n++) begin
      tick();
      if (trig_valid_o === 1'b1 && lat < 0) begin
        lat = n; got_h = trig_H_phi_o; got_v = trig_V_phi_o;
      end
    end
    total++; if (lat != 5) begin bad++; $display("FAIL wrap_latency: got %0d want 5", lat); end
    total++; if (got_h !== 16'h8001) begin bad++; $display("FAIL wrap_hphi: got %h want 8001", got_h); end
    total++; if (got_v !== 16'h0000) begin bad++; $display("FAIL wrap_vphi: got %h want 0000", got_v); end
    wait_idle("wrap");
    exp_drop = exp_drop + 16'd1;
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL wrap_dropped: got %0d want %0d", dropped_o, exp_drop); end

    // Same pair 6 cycles apart: stretch windows never overlap.
    H_pol_phi_i = 16'h8000; tick();
    H_pol_phi_i = '0;
    repeat (5) tick();
    H_pol_phi_i = 16'h0001; tick();
    H_pol_phi_i = '0;
    lat = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (trig_valid_o === 1'b1 || busy_o === 1'b1) lat++;
    end
    total++; if (lat != 0) begin bad++; $display("FAIL wrap_gap6: valid/busy cycles=%0d want 0", lat); end
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL wrap_gap6_dropped: got %0d want %0d", dropped_o, exp_drop); end
  endtask

  task automatic test_isolated();
    int seen;
    enable_i = 1'b1; pol_en_i = 2'b11; trig_ready_i = 1'b1;
    V_pol_phi_i = 16'h0008; tick();
    V_pol_phi_i = '0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (trig_valid_o === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL isolated_valid: valid cycles=%0d want 0", seen); end
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL isolated_dropped: got %0d want %0d", dropped_o, exp_drop); end
  endtask

  // Pulses every other cycle keep the coincidence alive; consumer stalls 20 cycles.
  task automatic test_holdoff_stall();
    int busy_cnt;
    enable_i = 1'b1; pol_en_i = 2'b01; trig_ready_i = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n <= 60; n++) begin
      V_pol_phi_i  = (n <= 20 && (n % 2) == 0) ? 16'h0060 : 16'h0000;
      trig_ready_i = (n >= 24);
      tick();                                // edge k+n
      if (n == 3) begin
        total++; if (trig_valid_o !== 1'b1 || trig_V_phi_o !== 16'h0060) begin bad++; $display("FAIL stall_issue: valid=%b v=%h want 1/0060", trig_valid_o, trig_V_phi_o); end
        total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL stall_start_dropped: got %0d want %0d", dropped_o, exp_drop); end
      end
      if (n >= 4 && n <= 23) begin
        total++; if (trig_valid_o !== 1'b1 || trig_V_phi_o !== 16'h0060 || trig_H_phi_o !== 16'h0) begin bad++; $display("FAIL stall_stable[%0d]: valid=%b v=%h h=%h", n, trig_valid_o, trig_V_phi_o, trig_H_phi_o); end
      end
      if (n == 23) begin
        total++; if (dropped_o !== exp_drop + 16'd20) begin bad++; $display("FAIL stall_dropped20: got %0d want %0d", dropped_o, exp_drop + 16'd20); end
      end
      if (n == 24) begin
        total++; if (trig_valid_o !== 1'b0 || trig_V_phi_o !== 16'h0) begin bad++; $display("FAIL stall_accept: valid=%b v=%h want 0/0000", trig_valid_o, trig_V_phi_o); end
      end
      if (n >= 24 && n <= 60 && busy_o === 1'b1) busy_cnt++;
      if (n == 56) begin
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_holdoff_exit: busy=%b want 0 at k+56", busy_o); end
      end
    end
    total++; if (busy_cnt != 32) begin bad++; $display("FAIL stall_holdoff_len: busy cycles=%0d want 32", busy_cnt); end
    exp_drop = exp_drop + 16'd23;
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL stall_dropped: got %0d want %0d", dropped_o, exp_drop); end
  endtask

  // V5 then V6 three cycles later: stretch windows overlap for exactly one cycle.
  task automatic disabled_pulse(output int seen);
    V_pol_phi_i = 16'h0020; tick();
    V_pol_phi_i = '0; tick(); tick();
    V_pol_phi_i = 16'h0040; tick();
    V_pol_phi_i = '0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (trig_valid_o === 1'b1) seen++;
    end
  endtask

  task automatic test_disabled();
    int seen;
    enable_i = 1'b0; pol_en_i = 2'b01; trig_ready_i = 1'b1;
    disabled_pulse(seen);
    exp_drop = exp_drop + 16'd1;
    total++; if (seen != 0) begin bad++; $display("FAIL disabled_valid: valid cycles=%0d want 0", seen); end
    total++; if (dropped_o !== exp_drop) begin bad++; $display("FAIL disabled_dropped: got %0d want %0d", dropped_o, exp_drop); end

    force dut.r_dropped = 16'hFFFF;
    tick();
    release dut.r_dropped;
    tick();
    disabled_pulse(seen);
    total++; if (dropped_o !== 16'hFFFF) begin bad++; $display("FAIL dropped_saturate: got %h want ffff", dropped_o); end
  endtask

  task automatic test_enable_fall_and_reset();
    enable_i = 1'b1; pol_en_i = 2'b01; trig_ready_i = 1'b0;
    V_pol_phi_i = 16'h0060; tick();
    V_pol_phi_i = '0;
    tick(); tick(); tick();                  // k+3
    total++; if (trig_valid_o !== 1'b1) begin bad++; $display("FAIL efall_issue: valid=%b want 1", trig_valid_o); end
    enable_i = 1'b0;
    repeat (3) tick();
    total++; if (trig_valid_o !== 1'b1 || trig_V_phi_o !== 16'h0060) begin bad++; $display("FAIL efall_hold: valid=%b v=%h want 1/0060", trig_valid_o, trig_V_phi_o); end
    #1 rst_n_i = 1'b0;
    #1;
    total++; if (trig_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL async_reset_valid: valid=%b busy=%b want 0/0", trig_valid_o, busy_o); end
    total++; if (dropped_o !== 16'h0 || trig_V_phi_o !== 16'h0) begin bad++; $display("FAIL async_reset_state: dropped=%h v=%h want 0/0", dropped_o, trig_V_phi_o); end
`ifdef DEADTIME_COUNT_EN
    total++; if (deadtime_o !== 32'd0) begin bad++; $display("FAIL async_reset_deadtime: got %0d want 0", deadtime_o); end
`endif
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_v();
    test_wrap();
    test_isolated();
    test_holdoff_stall();
    test_disabled();
    test_enable_fall_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
